multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 256 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle RV32I-subset datapath (lw, sw, R-type, I-type
// ALU, beq/bne, jal). A Moore FSM steps each instruction through its cycles.
// The state is registered. All datapath controls are decoded combinationally
// from the current state and the instruction fields.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   op[6:0]      in   opcode from the instruction register
//   funct3[2:0]  in   instruction bits [14:12]
//   funct7b5     in   instruction bit 30
//   zero         in   ALU zero flag for the current cycle's operation
//   alu_control  out  ALU select (0000 AND, 0001 OR, 0010 ADD, 0011 XOR,
//                     0110 SUB, 0111 SLT, 0100 null)
//   alu_src_a    out  00 PC, 01 old PC, 10 rs1
//   alu_src_b    out  00 rs2, 01 immediate, 10 constant 4
//   result_src   out  00 ALUOut, 01 memory data, 10 ALU result
//   imm_src      out  00 I, 01 S, 10 B, 11 J
//   adr_src      out  0 PC, 1 result
//   ir_write, pc_write, reg_write, mem_write   out  write enables
//   state[3:0]   out  current FSM state code (debug / verification)
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Internal ALU operation class; ALU_NONE yields alu_control 0000.
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FN   = 2'b10;
    localparam logic [1:0] ALU_NONE = 2'b11;

    state_t     state_r;
    state_t     next_s;
    logic [1:0] alu_op_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       branch_taken_s;

    // Next-state selection; unused codes 11-15 fall back to FETCH.
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_R:         next_s = S_EXECUTER;
                    OP_I:         next_s = S_EXECUTEI;
                    OP_BR:        next_s = S_BRANCH;
                    OP_JAL:       next_s = S_JAL;
                    default:      next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    next_s = S_MEMREAD;
                end else begin
                    next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD:  next_s = S_MEMWB;
            S_MEMWB:    next_s = S_FETCH;
            S_MEMWRITE: next_s = S_FETCH;
            S_EXECUTER: next_s = S_ALUWB;
            S_EXECUTEI: next_s = S_ALUWB;
            S_JAL:      next_s = S_ALUWB;
            S_ALUWB:    next_s = S_FETCH;
            S_BRANCH:   next_s = S_FETCH;
            default:    next_s = S_FETCH;
        endcase
    end

    // State register; reset holds the FSM in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Branch decision: beq takes on zero, bne on not-zero, others never.
    always_comb begin
        branch_taken_s = 1'b0;
        case (funct3)
            3'b000:  branch_taken_s = zero;
            3'b001:  branch_taken_s = ~zero;
            default: branch_taken_s = 1'b0;
        endcase
    end

    // Per-state datapath controls; anything not set stays 0.
    always_comb begin
        alu_op_s    = ALU_NONE;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        adr_src     = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b10;
                alu_op_s   = ALU_ADD;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                alu_op_s  = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op_s  = ALU_ADD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op_s  = ALU_FN;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op_s  = ALU_FN;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op_s   = ALU_SUB;
                pc_write_s = branch_taken_s;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op_s   = ALU_ADD;
                pc_write_s = 1'b1;
            end
            default: begin
                alu_op_s = ALU_NONE;
            end
        endcase
    end

    // ALU select. op[5] separates R-type (sub possible) from I-type, where
    // bit 30 is part of the immediate and must never select SUB.
    always_comb begin
        alu_control = 4'b0000;
        case (alu_op_s)
            ALU_ADD: alu_control = 4'b0010;
            ALU_SUB: alu_control = 4'b0110;
            ALU_FN: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] && funct7b5) begin
                            alu_control = 4'b0110;
                        end else begin
                            alu_control = 4'b0010;
                        end
                    end
                    3'b010:  alu_control = 4'b0111;
                    3'b100:  alu_control = 4'b0011;
                    3'b110:  alu_control = 4'b0001;
                    3'b111:  alu_control = 4'b0000;
                    default: alu_control = 4'b0100;
                endcase
            end
            default: alu_control = 4'b0000;
        endcase
    end

    // Immediate format depends only on the opcode, in every state.
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BR:   imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Write enables are gated by rst_n so an asserted reset kills them
    // immediately, without waiting for the state register to update.
    always_comb begin
        ir_write  = ir_write_s  & rst_n;
        pc_write  = pc_write_s  & rst_n;
        reg_write = reg_write_s & rst_n;
        mem_write = mem_write_s & rst_n;
    end

    assign state = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench. Instructions are issued one at a time (directed corner
// cases, then random opcodes/fields). The reference model describes each
// instruction class by its list of visited states and its total cycle count,
// and gives the expected controls for each named step.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [3:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .alu_control(alu_control),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 other.
    int seq_tab [7][5] = '{
        '{0, 1, 2, 3, 4},
        '{0, 1, 2, 5, 0},
        '{0, 1, 6, 8, 0},
        '{0, 1, 7, 8, 0},
        '{0, 1, 9, 0, 0},
        '{0, 1, 10, 8, 0},
        '{0, 1, 0, 0, 0}
    };
    int len_tab [7] = '{5, 4, 4, 4, 3, 4, 2};

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic       adr;
        logic       ir;
        logic       pc;
        logic       rw;
        logic       mw;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cls(input logic [6:0] o);
        case (o)
            OP_LW:   return 0;
            OP_SW:   return 1;
            OP_R:    return 2;
            OP_I:    return 3;
            OP_BR:   return 4;
            OP_JAL:  return 5;
            default: return 6;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            OP_SW:   return 2'b01;
            OP_BR:   return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // ALU operation requested by an R/I instruction; only register-register
    // instructions can ever be a subtract.
    function automatic logic [3:0] exp_exec_alu(input logic [6:0] o,
                                                input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == OP_R && f7) ? 4'b0110 : 4'b0010;
            3'd2:    return 4'b0111;
            3'd4:    return 4'b0011;
            3'd6:    return 4'b0001;
            3'd7:    return 4'b0000;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic exp_t exp_ctrl(input int s, input logic [6:0] o,
                                      input logic [2:0] f3, input logic f7, input logic z);
        exp_t e;
        e = '0;
        case (s)
            0:  begin e.ir = 1'b1; e.pc = 1'b1; e.b = 2'd2; e.alu = 4'b0010; e.res = 2'd2; end
            1:  begin e.a = 2'd1; e.b = 2'd1; e.alu = 4'b0010; end
            2:  begin e.a = 2'd2; e.b = 2'd1; e.alu = 4'b0010; end
            3:  begin e.adr = 1'b1; end
            4:  begin e.res = 2'd1; e.rw = 1'b1; end
            5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            6:  begin e.a = 2'd2; e.b = 2'd0; e.alu = exp_exec_alu(o, f3, f7); end
            7:  begin e.a = 2'd2; e.b = 2'd1; e.alu = exp_exec_alu(o, f3, f7); end
            8:  begin e.rw = 1'b1; end
            9:  begin
                    e.a = 2'd2; e.alu = 4'b0110;
                    e.pc = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? ~z : 1'b0);
                end
            10: begin e.a = 2'd1; e.b = 2'd2; e.alu = 4'b0010; e.pc = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check_outputs(input int s, input logic in_reset);
        exp_t e;
        e = exp_ctrl(s, op, funct3, funct7b5, zero);
        if (in_reset) begin
            e.ir = 1'b0; e.pc = 1'b0; e.rw = 1'b0; e.mw = 1'b0;
        end
        check_eq("state", 32'(state), 32'(s));
        check_eq("alu_control", 32'(alu_control), 32'(e.alu));
        check_eq("alu_src_a_b", 32'({alu_src_a, alu_src_b}), 32'({e.a, e.b}));
        check_eq("result_src", 32'(result_src), 32'(e.res));
        check_eq("imm_src", 32'(imm_src), 32'(exp_imm(op)));
        check_eq("adr_src", 32'(adr_src), 32'(e.adr));
        check_eq("writes_ir_pc_reg_mem", 32'({ir_write, pc_write, reg_write, mem_write}),
                 32'({e.ir, e.pc, e.rw, e.mw}));
    endtask

    // Entered just after a rising edge with the DUT in FETCH; runs one
    // instruction and returns just after the edge that brings FETCH back.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        int c;
        int n;
        int es;
        bit done;
        op = o; funct3 = f3; funct7b5 = f7;
        c = cls(o);
        n = 0;
        done = 1'b0;
        while (!done) begin
            zero = 1'($urandom_range(0, 1));
            #2;
            es = (n < len_tab[c]) ? seq_tab[c][n] : 0;
            check_outputs(es, 1'b0);
            @(posedge clk);
            #1;
            n++;
            if (state == 4'd0 || n >= 8) done = 1'b1;
        end
        check_eq("cycle_count", 32'(n), 32'(len_tab[c]));
    endtask

    logic [6:0] rop;

    initial begin
        rst_n = 1'b0; op = OP_SW; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_outputs(0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed corner cases.
        run_instr(OP_R,  3'b000, 1'b1);
        run_instr(OP_I,  3'b000, 1'b1);
        run_instr(OP_I,  3'b011, 1'b0);
        run_instr(OP_BR, 3'b000, 1'b0);
        run_instr(OP_BR, 3'b001, 1'b0);
        run_instr(OP_BR, 3'b101, 1'b0);
        run_instr(OP_LW, 3'b010, 1'b0);
        run_instr(OP_SW, 3'b010, 1'b0);
        run_instr(OP_JAL, 3'b000, 1'b0);
        run_instr(7'b0000000, 3'b000, 1'b0);

        // Random instruction mix.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: rop = OP_R;
                3: rop = OP_I;
                4: rop = OP_BR;
                5: rop = OP_JAL;
                default: rop = 7'($urandom);
            endcase
            run_instr(rop, 3'($urandom), 1'($urandom));
        end

        // Reset pulsed while a store is in MEMWRITE.
        op = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("sw_reached_memwrite", 32'(state), 32'd5);
        check_eq("sw_mem_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_mem_write", 32'(mem_write), 32'd0);
        check_eq("abort_state", 32'(state), 32'd0);
        check_outputs(0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(OP_LW, 3'b010, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
